// File: rtl/jtkunio_pal_arb_if.sv
// Palette RAM port bundle for jtkunio_pal_arb.
// The arbiter drives address, write data and write enable through the master modport.
// The single-port 512x8 RAM answers through the slave modport with one cycle of read latency.
//   ram_addr  9  RAM address
//   ram_din   8  RAM write data
//   ram_we    1  RAM write enable
//   ram_q     8  RAM read data, registered inside the RAM
interface jtkunio_pal_arb_if;
    logic [8:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we;
    logic [7:0] ram_q;

    modport master (
        output ram_addr,
        output ram_din,
        output ram_we,
        input  ram_q
    );

    modport slave (
        input  ram_addr,
        input  ram_din,
        input  ram_we,
        output ram_q
    );
endinterface

// File: rtl/jtkunio_pal_arb.sv
// jtkunio_pal_arb: shares one single-port 512x8 palette RAM between the colour mixer's video
// reads and CPU palette accesses.
//
// Per-cycle grant priority: video read > FIFO head write > pending CPU read.
// CPU writes are posted into a 2^FIFO_AW deep FIFO and retire in cycles without a video read.
// CPU reads stall the CPU until every earlier write has retired and the read has been served.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   vid_rd, vid_addr    video read request / address; vid_q returns data the next cycle
//   pal_cs, cpu_wrn     CPU chip select and active-low write strobe
//   cpu_addr, cpu_dout  CPU address and write data
//   pal_dout            CPU read data, held until the next read completes
//   cpu_wait            CPU stall (FIFO full on a write, or a read in flight)
//   ram                 palette RAM bundle (master side)
//
// Build option: define JTKUNIO_PAL_CLEAR_EN to zero the whole RAM after reset before the
// CPU is released.
module jtkunio_pal_arb #(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_rd,
    input  logic [8:0]        vid_addr,
    output logic [7:0]        vid_q,
    input  logic              pal_cs,
    input  logic              cpu_wrn,
    input  logic [8:0]        cpu_addr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        pal_dout,
    output logic              cpu_wait,
    jtkunio_pal_arb_if.master ram
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StDrain = 3'd1;
    localparam logic [2:0] StIssue = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StClear = 3'd4;

    logic [16:0]      fifo_mem [DEPTH];
    logic [FIFO_AW:0] wptr_q, wptr_d;
    logic [FIFO_AW:0] rptr_q, rptr_d;
    logic             fifo_empty, fifo_full;
    logic [16:0]      fifo_head;

    logic             wr_strobe, wr_strobe_q, wr_edge;
    logic             wr_pend_q, wr_pend_d;
    logic             wr_req, push, pop, wait_wr;

    logic [2:0]       state_q, state_d;
    logic             read_done_q, read_done_d;
    logic [7:0]       pal_dout_q, pal_dout_d;
    logic             rd_start, rd_wait, issue_go;

    logic             clearing, clr_wr, we_c;
    logic [8:0]       clr_cnt_q;

`ifdef JTKUNIO_PAL_CLEAR_EN
    localparam logic [2:0] ResetState = StClear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
        end else if (clr_wr) begin
            clr_cnt_q <= clr_cnt_q + 9'd1;
        end
    end
`else
    localparam logic [2:0] ResetState = StIdle;

    assign clr_cnt_q = '0;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                        (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign fifo_head  = fifo_mem[rptr_q[FIFO_AW-1:0]];

    assign clearing  = (state_q == StClear);
    assign wr_strobe = pal_cs & ~cpu_wrn;
    assign wr_edge   = wr_strobe & ~wr_strobe_q;
    // An edge that found the FIFO full stays pending until a slot opens.
    assign wr_req    = (wr_edge | wr_pend_q) & ~clearing;
    assign push      = wr_req & (~fifo_full | pop);
    assign wait_wr   = wr_req & ~push;
    assign wr_pend_d = wait_wr;

    assign rd_start  = pal_cs & cpu_wrn & ~read_done_q;
    assign issue_go  = ~vid_rd & fifo_empty;

    // RAM grant
    always_comb begin
        ram.ram_addr = vid_addr;
        ram.ram_din  = fifo_head[7:0];
        we_c         = 1'b0;
        pop          = 1'b0;
        clr_wr       = 1'b0;
        if (vid_rd) begin
            ram.ram_addr = vid_addr;
        end else if (clearing) begin
            ram.ram_addr = clr_cnt_q;
            ram.ram_din  = 8'h00;
            we_c         = 1'b1;
            clr_wr       = 1'b1;
        end else if (!fifo_empty) begin
            ram.ram_addr = fifo_head[16:8];
            we_c         = 1'b1;
            pop          = 1'b1;
        end else if (state_q == StIssue) begin
            ram.ram_addr = cpu_addr;
        end
    end

    // The grant logic is combinational, so keep the RAM safe while reset is held.
    assign ram.ram_we = we_c & rst_n;
    assign vid_q      = ram.ram_q;

    always_comb begin
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    end

    // CPU read sequencer
    always_comb begin
        state_d     = state_q;
        read_done_d = read_done_q & pal_cs;
        pal_dout_d  = pal_dout_q;
        case (state_q)
            StIdle: begin
                if (rd_start) state_d = StDrain;
            end
            StDrain: begin
                if (!pal_cs)         state_d = StIdle;
                else if (fifo_empty) state_d = StIssue;
            end
            StIssue: begin
                if (!pal_cs)       state_d = StIdle;
                else if (issue_go) state_d = StData;
            end
            StData: begin
                pal_dout_d  = ram.ram_q;
                read_done_d = pal_cs;
                state_d     = StIdle;
            end
            StClear: begin
                if (clr_wr && clr_cnt_q == 9'h1FF) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Stall held through DATA so the CPU only resumes once pal_dout carries the new byte.
    always_comb begin
        case (state_q)
            StIdle:           rd_wait = rd_start;
            StDrain, StIssue: rd_wait = pal_cs;
            default:          rd_wait = 1'b1;
        endcase
        cpu_wait = wait_wr | rd_wait;
    end

    assign pal_dout = pal_dout_q;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q[FIFO_AW-1:0]] <= {cpu_addr, cpu_dout};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_pend_q   <= 1'b0;
            state_q     <= ResetState;
            read_done_q <= 1'b0;
            pal_dout_q  <= 8'h00;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            wr_strobe_q <= wr_strobe;
            wr_pend_q   <= wr_pend_d;
            state_q     <= state_d;
            read_done_q <= read_done_d;
            pal_dout_q  <= pal_dout_d;
        end
    end

endmodule
